// File: rtl/uart_pkg.sv
// Shared types and constants for the UART mirror: frame width and the
// receiver/transmitter state encodings.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_mirror_if.sv
// Serial pin pair of the mirror; the board/line side is the master, the
// mirror itself is the slave.
interface uart_mirror_if;

    logic serial_rx;
    logic serial_tx;

    modport master (output serial_rx, input serial_tx);
    modport slave  (input serial_rx, output serial_tx);

endinterface

// File: rtl/uart_serial_tx.sv
// 8N1 transmitter: accepts a byte on load while idle and shifts it out LSB
// first on a registered serial line.
module uart_serial_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 78
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 load,
    output logic                 busy,
    output logic                 serial_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    // STOP ends one cycle early: the IDLE/load cycle supplies the last stop
    // cycle, so back-to-back frames take exactly ten bit times.
    localparam logic [CW-1:0] STOP_CNT = CW'(CLKS_PER_BIT - 2);

    tx_state_t            r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt,   w_cnt_nxt;
    logic [2:0]           r_idx,   w_idx_nxt;
    logic [DATA_BITS-1:0] r_data,  w_data_nxt;
    logic                 r_tx,    w_tx_nxt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_tx_nxt    = r_tx;
        case (r_state)
            TX_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                w_tx_nxt  = 1'b1;
                if (load) begin
                    w_data_nxt  = data;
                    w_state_nxt = TX_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            TX_START: begin
                if (r_cnt == LAST_CNT) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = TX_DATA;
                    w_tx_nxt    = r_data[0];
                end
            end
            TX_DATA: begin
                if (r_cnt == LAST_CNT) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = TX_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                        w_tx_nxt  = r_data[r_idx + 3'd1];
                    end
                end
            end
            TX_STOP: begin
                w_tx_nxt = 1'b1;
                if (r_cnt == STOP_CNT) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = TX_IDLE;
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: flops update with non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    assign busy      = (r_state != TX_IDLE);
    assign serial_tx = r_tx;

endmodule

// File: rtl/uart_mirror.sv
// UART loopback: synchronizes serial_rx, receives 8N1 frames, buffers one
// byte and retransmits it unchanged through uart_serial_tx.
module uart_mirror
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 78
) (
    input  logic          clk,
    input  logic          rst,
    uart_mirror_if.slave  uart
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

    logic                 r_rx_meta, r_rx_sync;
    rx_state_t            r_rx_state, w_rx_state_nxt;
    logic [CW-1:0]        r_rx_cnt,   w_rx_cnt_nxt;
    logic [2:0]           r_rx_idx,   w_rx_idx_nxt;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                 r_rx_wait_high, w_rx_wait_high_nxt;
    logic                 w_rx_valid;

    logic [DATA_BITS-1:0] r_buf_data;
    logic                 r_buf_full;
    logic                 w_load;
    logic                 w_tx_busy;
    logic                 w_serial_tx;

    // Two-flop synchronizer; both stages idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart.serial_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_comb begin
        w_rx_state_nxt     = r_rx_state;
        w_rx_cnt_nxt       = r_rx_cnt + 1'b1;
        w_rx_idx_nxt       = r_rx_idx;
        w_rx_shift_nxt     = r_rx_shift;
        w_rx_wait_high_nxt = r_rx_wait_high;
        w_rx_valid         = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                w_rx_idx_nxt = '0;
                if (r_rx_sync) begin
                    w_rx_wait_high_nxt = 1'b0;
                end else if (!r_rx_wait_high) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == HALF_CNT) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == LAST_CNT) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    w_rx_idx_nxt   = r_rx_idx + 3'd1;
                    if (r_rx_idx == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == LAST_CNT) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = RX_IDLE;
                    if (r_rx_sync) begin
                        w_rx_valid = 1'b1;
                    end else begin
                        w_rx_wait_high_nxt = 1'b1;
                    end
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state     <= RX_IDLE;
            r_rx_cnt       <= '0;
            r_rx_idx       <= '0;
            r_rx_shift     <= '0;
            r_rx_wait_high <= 1'b0;
        end else begin
            r_rx_state     <= w_rx_state_nxt;
            r_rx_cnt       <= w_rx_cnt_nxt;
            r_rx_idx       <= w_rx_idx_nxt;
            r_rx_shift     <= w_rx_shift_nxt;
            r_rx_wait_high <= w_rx_wait_high_nxt;
        end
    end

    // A byte arriving while the buffer is still full is dropped; the older byte wins.
    assign w_load = r_buf_full && !w_tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_data <= '0;
            r_buf_full <= 1'b0;
        end else if (w_rx_valid && !r_buf_full) begin
            r_buf_data <= r_rx_shift;
            r_buf_full <= 1'b1;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    uart_serial_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .data      (r_buf_data),
        .load      (w_load),
        .busy      (w_tx_busy),
        .serial_tx (w_serial_tx)
    );

    assign uart.serial_tx = w_serial_tx;

endmodule

// File: tb/tb_uart_mirror.sv
// Bench for uart_mirror: directed frames into two instances (78 and 16 clocks
// per bit); a monitor decodes serial_tx and checks it against queued bytes.
module tb_uart_mirror;

    localparam int CPB0 = 78;
    localparam int CPB1 = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_mirror_if u0 ();
    uart_mirror_if u1 ();

    uart_mirror #(.CLKS_PER_BIT(CPB0)) dut0 (.clk(clk), .rst(rst), .uart(u0));
    uart_mirror #(.CLKS_PER_BIT(CPB1)) dut1 (.clk(clk), .rst(rst), .uart(u1));

    typedef struct {
        logic [7:0] data;
        int         start_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    bit   busy0 = 1'b0;
    bit   busy1 = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    function automatic logic tx_line(input int idx);
        return (idx == 0) ? u0.serial_tx : u1.serial_tx;
    endfunction

    task automatic set_rx(input int idx, input logic v);
        if (idx == 0) u0.serial_rx = v;
        else          u1.serial_rx = v;
    endtask

    // Drives one frame; called and returns at posedge+1.
    task automatic send(input int idx, input int cpb, input logic [7:0] d, input logic stop);
        exp_t       e;
        logic [9:0] bits;
        bits        = {stop, d, 1'b0};
        e.data      = d;
        e.start_cyc = cyc;
        if (stop) begin
            if (idx == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        for (int b = 0; b < 10; b++) begin
            set_rx(idx, bits[b]);
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int idx, input string name, input int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(posedge clk);
            n++;
            done = (idx == 0) ? (q0.size() == 0 && !busy0) : (q1.size() == 0 && !busy1);
        end
        @(posedge clk);
        #1;
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic count_low(input int idx, input int ncyc, output int lows);
        lows = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (tx_line(idx) !== 1'b1) lows++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic monitor(input int idx, input int cpb);
        logic       prev, cur;
        logic [9:0] want, got;
        exp_t       e;
        int         bad, n, t0;
        bit         have, aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            cur = tx_line(idx);
            if (prev === 1'b1 && cur === 1'b0 && !rst) begin
                t0 = cyc;
                if (idx == 0) busy0 = 1'b1;
                else          busy1 = 1'b1;
                have   = (idx == 0) ? (q0.size() > 0) : (q1.size() > 0);
                e.data = 8'h00;
                e.start_cyc = 0;
                if (have) begin
                    if (idx == 0) e = q0.pop_front();
                    else          e = q1.pop_front();
                end
                check($sformatf("frame_expected%0d", idx), {31'd0, have}, 32'd1);
                want    = {1'b1, e.data, 1'b0};
                got     = '0;
                bad     = 0;
                aborted = 1'b0;
                n       = 0;
                while (n < 10 * cpb && !aborted) begin
                    if (n > 0) begin
                        @(negedge clk);
                        cur = tx_line(idx);
                    end
                    if (rst) begin
                        aborted = 1'b1;
                    end else begin
                        if (n % cpb == cpb / 2) got[n / cpb] = cur;
                        if (cur !== want[n / cpb]) bad++;
                    end
                    n++;
                end
                if (have && !aborted) begin
                    check($sformatf("frame_bits%0d_%02h", idx, e.data), {22'd0, got}, {22'd0, want});
                    check($sformatf("bit_levels%0d_%02h", idx, e.data), bad, 0);
                    check_range($sformatf("latency%0d_%02h", idx, e.data), t0 - e.start_cyc,
                                (19 * cpb) / 2, (19 * cpb) / 2 + 6);
                end
                if (idx == 0) busy0 = 1'b0;
                else          busy1 = 1'b0;
            end
            prev = cur;
        end
    endtask

    initial monitor(0, CPB0);
    initial monitor(1, CPB1);

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        rst = 1'b1;
        u0.serial_rx = 1'b1;
        u1.serial_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_tx0", {31'd0, u0.serial_tx}, 32'd1);
        check("reset_tx1", {31'd0, u1.serial_tx}, 32'd1);
        @(posedge clk);
        #1;

        // Single byte.
        send(0, CPB0, 8'hCD, 1'b1);
        drain(0, "drain_cd", 3000);

        // Back-to-back frames, then the line must idle high.
        send(0, CPB0, 8'h00, 1'b1);
        send(0, CPB0, 8'hFF, 1'b1);
        send(0, CPB0, 8'h55, 1'b1);
        drain(0, "drain_b2b", 3000);
        count_low(0, 2 * CPB0, lows);
        check("idle_after_b2b", lows, 0);

        // Short glitch shorter than half a bit.
        set_rx(0, 1'b0);
        repeat (20) @(posedge clk);
        #1 set_rx(0, 1'b1);
        count_low(0, 12 * CPB0, lows);
        check("glitch_no_echo", lows, 0);

        // Framing error, then a valid byte.
        send(0, CPB0, 8'hA5, 1'b0);
        set_rx(0, 1'b1);
        repeat (2 * CPB0) @(posedge clk);
        #1;
        send(0, CPB0, 8'h3C, 1'b1);
        drain(0, "drain_3c", 3000);

        // Reset in the middle of an echo.
        send(0, CPB0, 8'hCD, 1'b1);
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("tx_after_reset", {31'd0, u0.serial_tx}, 32'd1);
        @(posedge clk);
        #1;
        count_low(0, 12 * CPB0, lows);
        check("idle_after_reset", lows, 0);
        send(0, CPB0, 8'h12, 1'b1);
        drain(0, "drain_12", 3000);

        // Short bit period instance.
        send(1, CPB1, 8'h81, 1'b1);
        drain(1, "drain_81", 1000);
        count_low(1, 2 * CPB1, lows);
        check("idle_cpb16", lows, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_mirror.md
Name: uart_mirror

Overview:
- UART loopback ("mirror") block: receives 8N1 frames on serial_rx and retransmits each correctly framed byte unchanged on serial_tx at the same bit rate.
- Sits at the top of the FPGA fabric, clocked from the 72 MHz PLL output, directly on the board UART pins.
- Receiver and transmitter share one CLKS_PER_BIT timing parameter; no host-side handshake.

Parameters:
- CLKS_PER_BIT, 78, clock cycles per UART bit (72 MHz / 921600 baud, truncated); legal range 8..65535.

Ports:
- clk  input  1  system clock, 72 MHz nominal; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- serial_rx  input  1  asynchronous UART line in; idle high.
- serial_tx  output  1  UART line out; idle high.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - serial_tx = 1 on the cycle after rst is sampled high.
  - Receiver and transmitter return to IDLE; holding buffer empty; all counters 0.
  - Reset mid-frame aborts the frame; the partial byte is never emitted.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Every bit lasts exactly CLKS_PER_BIT cycles.
- RX input: serial_rx passes through a 2-flop synchronizer. All receiver decisions use the synchronized value.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized low enters START with the counter cleared.
  - START: at count CLKS_PER_BIT/2 - 1 (mid start bit), sample the line. Low -> DATA. High -> glitch; return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles thereafter; 8 samples shifted in LSB first.
  - STOP: sample one bit later. High -> one-cycle internal rx_valid with the byte, then IDLE. Low -> framing error; byte discarded, then IDLE (no break detection). Wait for the line to be high before re-arming.
- Holding buffer: one byte plus a full flag.
  - rx_valid sets it.
  - The transmitter loads from it in the cycle it is IDLE and the flag is full, which clears the flag.
  - rx_valid while the flag is already full: the new byte is dropped and the buffered byte is kept. No status output.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - serial_tx is registered.
  - START drives 0 for CLKS_PER_BIT cycles.
  - DATA drives bit i (i = 0..7) for CLKS_PER_BIT cycles each.
  - STOP drives 1 for CLKS_PER_BIT cycles.
  - From IDLE with the buffer full, serial_tx falls one cycle after the load.
- Latency: from the synchronized start-bit falling edge to the echoed start-bit falling edge is 9.5 bit times plus at most 4 clk cycles.
- Rate matching: back-to-back input frames (stop bit followed immediately by start bit) are echoed back-to-back without loss. This holds because tx consumes exactly 10 bit times per frame and the buffer absorbs the half-bit skew.
- Counters are sized with $clog2(CLKS_PER_BIT). The bit index is 3 bits.

Decomposition:
- Shared package uart_pkg:
  - DATA_BITS = 8.
  - Enum rx_state_t {IDLE, START, DATA, STOP}.
  - Enum tx_state_t {IDLE, START, DATA, STOP}.
- Sub-module uart_serial_tx (clk, rst, data[7:0], load, busy, serial_tx) holds the transmit FSM.
- The receiver, synchronizer and holding buffer live in uart_mirror.

Test Plan:
- Send 0xCD at CLKS_PER_BIT=78 after reset release -> serial_tx emits 0,1,0,1,1,0,0,1,1,1. Each level is held 78 cycles; the start edge is within 9.5 bits + 4 cycles of the input start edge.
- Send 0x00, 0xFF, 0x55 back-to-back -> identical three frames echoed in order with no gaps lost; serial_tx idles high afterwards.
- 20-cycle low glitch on serial_rx (under a half bit) -> serial_tx stays 1 for the next 12 bit times.
- Frame 0xA5 with stop bit forced low -> no echo. A following valid 0x3C is echoed correctly.
- Assert rst for 1 cycle mid echo of 0xCD -> serial_tx = 1 the next cycle and stays idle. A subsequent 0x12 is echoed correctly.
- Override CLKS_PER_BIT=16, send 0x81 -> echo 0,1,0,0,0,0,0,0,1,1 with 16-cycle bits.
